// File: rtl/ets_sweep_if.sv
// Result stream from the sweep engine: packed per-channel counts with valid/ready.
interface ets_sweep_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned ACC_W = 32
);
  logic [CH*ACC_W-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ets_sweep_core.sv
// Multi-channel equivalent-time-sampling sweep engine: per phase point, count highs per channel,
// hand the counts out, step the MMCM phase; optionally step the phase back after the sweep.
module ets_sweep_core #(
  parameter int unsigned CH         = 4,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned STEPS_W    = 16,
  parameter int unsigned PS_TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CH-1:0]      data_in_i,
  input  logic [ACC_W-1:0]   average_i,
  input  logic [STEPS_W-1:0] num_steps_i,
  input  logic               dir_i,
  input  logic               ret_mode_i,
  input  logic               start_i,
  input  logic               abort_i,
  ets_sweep_if.master        out_if,
  output logic [STEPS_W-1:0] step_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               ps_en_o,
  output logic               ps_incdec_o,
  output logic               ps_clk_o,
  input  logic               ps_done_i
);

  localparam int unsigned TmoW = $clog2(PS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StAccum, StPresent, StPsReq, StPsWait, StRetReq, StRetWait
  } state_e;

  state_e state_q, state_d;

  logic [CH-1:0][ACC_W-1:0] acc_q, acc_d, acc_sum, data_q, data_d;
  logic [ACC_W-1:0]   avg_q, avg_d, cyc_q, cyc_d;
  logic [STEPS_W-1:0] nsteps_q, nsteps_d, step_idx_q, step_idx_d, ret_cnt_q, ret_cnt_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic dir_q, dir_d, ret_q, ret_d, abort_q, abort_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic ps_en_q, ps_en_d, ps_incdec_q, ps_incdec_d;

  logic wait_st, mmcm_st, tmo_hit, last_pt, last_ret, abort_pend, accum_last, cfg_load;

  assign wait_st    = (state_q == StPsWait) || (state_q == StRetWait);
  assign mmcm_st    = wait_st || (state_q == StPsReq) || (state_q == StRetReq);
  assign tmo_hit    = wait_st && !ps_done_i && (tmo_q >= TmoW'(PS_TIMEOUT - 1));
  assign last_pt    = step_idx_q == (nsteps_q - STEPS_W'(1));
  assign last_ret   = ret_cnt_q == (nsteps_q - STEPS_W'(1));
  assign abort_pend = abort_q || abort_i;
  assign accum_last = cyc_q == (avg_q - ACC_W'(1));
  assign cfg_load   = (state_q == StIdle) && (state_d == StAccum);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i && !abort_i && num_steps_i != '0) state_d = StAccum;
      StAccum:   if (abort_i) state_d = StIdle;
                 else if (accum_last) state_d = StPresent;
      StPresent: if (abort_i) state_d = StIdle;
                 else if (out_if.ready) state_d = StPsReq;
      StPsReq:   state_d = StPsWait;
      StPsWait: begin
        // An MMCM step in flight is always allowed to finish before abort takes effect.
        if (ps_done_i) begin
          if (abort_pend)   state_d = StIdle;
          else if (last_pt) state_d = ret_q ? StRetReq : StIdle;
          else              state_d = StAccum;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StRetReq:  state_d = StRetWait;
      StRetWait: begin
        if (ps_done_i)    state_d = (abort_pend || last_ret) ? StIdle : StRetReq;
        else if (tmo_hit) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      acc_sum[c] = acc_q[c] + ACC_W'(data_in_i[c]);
    end

    acc_d = acc_q;
    cyc_d = cyc_q;
    if (state_d == StAccum && state_q != StAccum) begin
      acc_d = '0;
      cyc_d = '0;
    end else if (state_q == StAccum) begin
      acc_d = acc_sum;
      cyc_d = cyc_q + ACC_W'(1);
    end

    // Final ACCUM sample goes straight into the presented result.
    data_d = (state_q == StAccum && state_d == StPresent) ? acc_sum : data_q;

    avg_d    = avg_q;
    nsteps_d = nsteps_q;
    dir_d    = dir_q;
    ret_d    = ret_q;
    if (cfg_load) begin
      avg_d    = (average_i == '0) ? ACC_W'(1) : average_i;
      nsteps_d = num_steps_i;
      dir_d    = dir_i;
      ret_d    = ret_mode_i;
    end

    step_idx_d = step_idx_q;
    if (cfg_load) step_idx_d = '0;
    else if (state_q == StPsWait && state_d == StAccum) step_idx_d = step_idx_q + STEPS_W'(1);

    ret_cnt_d = ret_cnt_q;
    if (state_q == StPsWait && state_d == StRetReq) ret_cnt_d = '0;
    else if (state_q == StRetWait && state_d == StRetReq) ret_cnt_d = ret_cnt_q + STEPS_W'(1);

    tmo_d   = wait_st ? tmo_q + TmoW'(1) : '0;
    abort_d = (state_d != StIdle) && (abort_q || (abort_i && mmcm_st));

    error_d = error_q;
    if (cfg_load) error_d = 1'b0;
    if (tmo_hit)  error_d = 1'b1;

    done_d = ((state_q == StIdle) && start_i && !abort_i && num_steps_i == '0) ||
             (wait_st && ps_done_i && !abort_pend && state_d == StIdle);

    valid_d     = state_d == StPresent;
    busy_d      = state_d != StIdle;
    ps_en_d     = (state_d == StPsReq) || (state_d == StRetReq);
    ps_incdec_d = (state_d == StPsReq) ? dir_q : ((state_d == StRetReq) ? ~dir_q : 1'b0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      data_q      <= '0;
      avg_q       <= '0;
      cyc_q       <= '0;
      nsteps_q    <= '0;
      step_idx_q  <= '0;
      ret_cnt_q   <= '0;
      tmo_q       <= '0;
      dir_q       <= 1'b0;
      ret_q       <= 1'b0;
      abort_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ps_en_q     <= 1'b0;
      ps_incdec_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      data_q      <= data_d;
      avg_q       <= avg_d;
      cyc_q       <= cyc_d;
      nsteps_q    <= nsteps_d;
      step_idx_q  <= step_idx_d;
      ret_cnt_q   <= ret_cnt_d;
      tmo_q       <= tmo_d;
      dir_q       <= dir_d;
      ret_q       <= ret_d;
      abort_q     <= abort_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ps_en_q     <= ps_en_d;
      ps_incdec_q <= ps_incdec_d;
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign step_idx_o   = step_idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign ps_en_o      = ps_en_q;
  assign ps_incdec_o  = ps_incdec_q;
  assign ps_clk_o     = clk_i;

endmodule

// File: tb/tb_ets_sweep_core.sv
// Scoreboard bench for ets_sweep_core: expected beats, phase steps and done pulses are queued
// from a point-level model when a sweep is launched; a monitor pops them as the DUT emits.
module tb_ets_sweep_core;
  localparam int CH = 4;
  localparam int ACC_W = 32;
  localparam int STEPS_W = 16;
  localparam int DW = CH * ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] data_in = '0;
  logic [ACC_W-1:0] average = '0;
  logic [STEPS_W-1:0] num_steps = '0;
  logic dir = 1'b0, ret_mode = 1'b0, start = 1'b0, abort = 1'b0, ps_done = 1'b0;
  logic [STEPS_W-1:0] step_idx;
  logic busy, done, error, ps_en, ps_incdec, ps_clk;
  logic mute = 1'b0;

  ets_sweep_if #(.CH(CH), .ACC_W(ACC_W)) sif ();

  ets_sweep_core #(
    .CH(CH), .ACC_W(ACC_W), .STEPS_W(STEPS_W), .PS_TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in), .average_i(average),
    .num_steps_i(num_steps), .dir_i(dir), .ret_mode_i(ret_mode), .start_i(start),
    .abort_i(abort), .out_if(sif), .step_idx_o(step_idx), .busy_o(busy), .done_o(done),
    .error_o(error), .ps_en_o(ps_en), .ps_incdec_o(ps_incdec), .ps_clk_o(ps_clk),
    .ps_done_i(ps_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]      data;
    logic [STEPS_W-1:0] idx;
  } beat_t;

  beat_t exp_beats[$];
  logic  exp_ps[$];
  int    exp_done = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every channel that is held high counts once per sample of the point.
  function automatic logic [DW-1:0] model_point(input logic [CH-1:0] pat, input int avg_eff);
    logic [DW-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c*ACC_W +: ACC_W] = pat[c] ? ACC_W'(avg_eff) : '0;
    return r;
  endfunction

  task automatic push_sweep(input logic [CH-1:0] pat, input int avg, input int n,
                            input logic d, input logic r);
    int avg_eff = (avg == 0) ? 1 : avg;
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = model_point(pat, avg_eff);
      b.idx  = STEPS_W'(i);
      exp_beats.push_back(b);
      exp_ps.push_back(d);
    end
    if (r) for (int i = 0; i < n; i++) exp_ps.push_back(~d);
    exp_done++;
  endtask

  task automatic start_sweep(input logic [CH-1:0] pat, input int avg, input int n,
                             input logic d, input logic r);
    @(posedge clk); #1;
    data_in = pat; average = ACC_W'(avg); num_steps = STEPS_W'(n);
    dir = d; ret_mode = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < budget);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_sig(input string name, input int sel, input int budget);
    int k = 0;
    logic seen;
    do begin
      @(negedge clk);
      k++;
      seen = (sel == 0) ? sif.valid : ps_en;
    end while (!seen && k < budget);
    check(name, seen, 1'b1);
  endtask

  task automatic end_of_test(input string name);
    repeat (2) @(negedge clk);
    check({name, "_beats_left"}, exp_beats.size(), 0);
    check({name, "_ps_left"}, exp_ps.size(), 0);
    check({name, "_done_left"}, exp_done, 0);
    exp_beats.delete();
    exp_ps.delete();
    exp_done = 0;
  endtask

  task automatic run_sweep(input string name, input logic [CH-1:0] pat, input int avg,
                           input int n, input logic d, input logic r);
    push_sweep(pat, avg, n, d, r);
    start_sweep(pat, avg, n, d, r);
    @(negedge clk);
    check({name, "_busy"}, busy, 1'b1);
    check({name, "_err_clr"}, error, 1'b0);
    wait_idle(3000);
    end_of_test(name);
  endtask

  // MMCM model: ps_done pulses two cycles after each ps_en unless muted.
  initial begin
    forever begin
      @(negedge clk);
      if (ps_en && !mute) begin
        repeat (2) @(posedge clk);
        #1 ps_done = 1'b1;
        @(posedge clk);
        #1 ps_done = 1'b0;
      end
    end
  end

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sif.valid && sif.ready) begin
          if (exp_beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h expected none", sif.data);
          end else begin
            b = exp_beats.pop_front();
            check("beat_data", sif.data, b.data);
            check("beat_idx", step_idx, b.idx);
          end
        end
        if (ps_en) begin
          if (exp_ps.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ps_en: got incdec %0b expected no request", ps_incdec);
          end else begin
            check("ps_incdec", ps_incdec, exp_ps.pop_front());
          end
        end
        if (done) begin
          if (exp_done == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            exp_done--;
            checks++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] pat;
    int avg, n;
    logic d, r;
    sif.ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", sif.valid, 1'b0);
    check("rst_data", sif.data, '0);
    check("rst_idx", step_idx, '0);
    check("rst_ps_en", ps_en, 1'b0);
    check("rst_err", error, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_sweep("basic", 4'b0101, 4, 3, 1'b1, 1'b0);
    run_sweep("return", 4'b0101, 4, 3, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      pat = CH'($urandom_range(0, 15));
      avg = $urandom_range(0, 6);
      n   = $urandom_range(1, 4);
      d   = 1'($urandom);
      r   = 1'($urandom);
      run_sweep("random", pat, avg, n, d, r);
    end

    // Backpressure on point 1.
    sif.ready = 1'b0;
    push_sweep(4'b0101, 4, 3, 1'b1, 1'b0);
    start_sweep(4'b0101, 4, 3, 1'b1, 1'b0);
    wait_sig("hold_v0", 0, 100);
    @(posedge clk); #1 sif.ready = 1'b1;
    @(posedge clk); #1 sif.ready = 1'b0;
    wait_sig("hold_v1", 0, 100);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      check("hold_valid", sif.valid, 1'b1);
      check("hold_data", sif.data, model_point(4'b0101, 4));
      check("hold_idx", step_idx, STEPS_W'(1));
      check("hold_ps_en", ps_en, 1'b0);
    end
    @(posedge clk); #1 sif.ready = 1'b1;
    wait_idle(1000);
    end_of_test("hold");

    // ps_done never returns.
    mute = 1'b1;
    exp_beats.push_back('{data: model_point(4'b0011, 2), idx: '0});
    exp_ps.push_back(1'b1);
    start_sweep(4'b0011, 2, 2, 1'b1, 1'b0);
    wait_sig("tmo_ps_en", 1, 100);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 16) begin
        check("tmo_err_early", error, 1'b0);
        check("tmo_busy_early", busy, 1'b1);
      end
      if (k == 17) begin
        check("tmo_err", error, 1'b1);
        check("tmo_busy", busy, 1'b0);
      end
    end
    mute = 1'b0;
    end_of_test("timeout");
    run_sweep("after_tmo", 4'b1000, 3, 2, 1'b1, 1'b0);

    // Abort during PS_WAIT with one-cycle accumulation.
    exp_beats.push_back('{data: model_point(4'b1110, 1), idx: '0});
    exp_ps.push_back(1'b0);
    start_sweep(4'b1110, 0, 3, 1'b0, 1'b0);
    wait_sig("abort_ps_en", 1, 100);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy_hold", busy, 1'b1);
    @(negedge clk);
    check("abort_idle", busy, 1'b0);
    repeat (10) @(negedge clk);
    end_of_test("abort");

    // Abort and start together in IDLE.
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1; num_steps = STEPS_W'(2);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 1'b0);
    end_of_test("abort_start");

    // Asynchronous reset mid-ACCUM.
    start_sweep(4'b1111, 50, 2, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", sif.valid, 1'b0);
    check("arst_data", sif.data, '0);
    check("arst_ps_en", ps_en, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    end_of_test("arst");

    // Zero-length sweep: done only.
    exp_done = 1;
    start_sweep(4'b1111, 3, 0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("zero_busy", busy, 1'b0);
    end_of_test("zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
